// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, entry layout and fault helper.
package inst_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_W             = 32;
    localparam int          INST_W           = 32;
    localparam int          FAULT_W          = 1;
    localparam int          ENTRY_W          = PC_W + INST_W + FAULT_W;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic [FAULT_W-1:0] fault;
    } fetch_entry_t;

    // A fetch faults when the ROM misses or the PC is not word aligned.
    function automatic logic fetch_fault(input logic accessable, input logic [1:0] pc_lsb);
        return (!accessable) || (pc_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; head holds its last value while empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] last_head_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign pop_s  = pop && !empty;
    assign push_s = push && (!full || pop_s);
    assign head   = empty ? last_head_r : mem_r[rd_ptr_r];

    // Pointer, occupancy and storage update; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r    <= {AW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            last_head_r <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            last_head_r <= head;
            if (flush) begin
                rd_ptr_r <= {AW{1'b0}};
                wr_ptr_r <= {AW{1'b0}};
                count_r  <= {CW{1'b0}};
            end else begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= push_data;
                    wr_ptr_r        <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, RUN/HALT control, fetch FIFO to decode.
// Optional FETCH_PERF_EN build adds a pushed-entry counter on perf_fetch_cnt.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_accessable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    output logic [31:0] perf_fetch_cnt
);

    logic [31:0]  pc_r;
    fetch_state_e state_r;
    logic         full_s;
    logic         empty_s;
    logic         push_s;
    logic         pop_s;
    logic         fault_s;
    fetch_entry_t push_entry_s;
    fetch_entry_t head_s;

    assign rom_addr  = pc_r;
    assign out_valid = !empty_s;
    assign out_pc    = head_s.pc;
    assign out_inst  = head_s.inst;
    assign out_fault = head_s.fault;

    // Push/pop qualification and entry formation from the current ROM response.
    always_comb begin
        pop_s   = out_valid && out_ready;
        fault_s = fetch_fault(rom_accessable, pc_r[1:0]);
        if ((state_r == ST_RUN) && !redirect_valid && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        push_entry_s.pc    = pc_r;
        push_entry_s.inst  = fault_s ? NOP_INST : rom_data;
        push_entry_s.fault = fault_s;
    end

    // PC and RUN/HALT control; redirect has top priority, a fault push parks the PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r    <= RESET_PC;
            state_r <= ST_RUN;
        end else if (redirect_valid) begin
            pc_r    <= redirect_pc;
            state_r <= ST_RUN;
        end else if (push_s) begin
            if (fault_s) begin
                state_r <= ST_HALT;
            end else begin
                pc_r <= pc_r + 32'd4;
            end
        end else begin
            pc_r    <= pc_r;
            state_r <= state_r;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ENTRY_W)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .push_data (push_entry_s),
        .full      (full_s),
        .empty     (empty_s),
        .head      (head_s)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_cnt_r;

    // Counts every pushed entry including faults; survives redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cnt_r <= 32'h0000_0000;
        end else if (push_s) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign perf_fetch_cnt = perf_cnt_r;
`else
    assign perf_fetch_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a small behavioural ROM.
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_accessable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic [31:0] perf_fetch_cnt;

    int          checks;
    int          failures;
    logic [31:0] bad_addr;

    inst_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_accessable (rom_accessable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault),
        .perf_fetch_cnt (perf_fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: fixed words at 0x0/0x4/0x8, {C0DE, addr[15:0]} elsewhere, one selectable miss address.
    always_comb begin
        case (rom_addr)
            32'h0000_0000: rom_data = 32'h1111_0001;
            32'h0000_0004: rom_data = 32'h2222_0002;
            32'h0000_0008: rom_data = 32'h3333_0003;
            default:       rom_data = {16'hC0DE, rom_addr[15:0]};
        endcase
        rom_accessable = (rom_addr != bad_addr);
    end

    task automatic apply_reset(input logic ready);
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = ready;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bad_addr = 32'hFFFF_FFF0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 32'h0 || out_pc !== 32'h0 ||
            out_inst !== 32'h0 || out_fault !== 1'b0 || perf_fetch_cnt !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: valid=%b addr=%h pc=%h inst=%h fault=%b perf=%h expected 0 everywhere",
                     out_valid, rom_addr, out_pc, out_inst, out_fault, perf_fetch_cnt);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc   [3];
        logic [31:0] exp_inst [3];
        logic [31:0] exp_perf;
        exp_pc   = '{32'h0, 32'h4, 32'h8};
        exp_inst = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        bad_addr = 32'hFFFF_FFF0;
        apply_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_inst !== exp_inst[i] || out_fault !== 1'b0) begin
                failures++;
                $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h fault=%b expected 1 %h %h 0",
                         i, out_valid, out_pc, out_inst, out_fault, exp_pc[i], exp_inst[i]);
            end
        end
`ifdef FETCH_PERF_EN
        exp_perf = 32'd3;
`else
        exp_perf = 32'd0;
`endif
        checks++;
        if (perf_fetch_cnt !== exp_perf) begin
            failures++;
            $display("FAIL stream_perf: got %0d expected %0d", perf_fetch_cnt, exp_perf);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [3];
        exp_pc   = '{32'h4, 32'h8, 32'hC};
        bad_addr = 32'hFFFF_FFF0;
        apply_reset(1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || rom_addr !== 32'h8) begin
            failures++;
            $display("FAIL bp_hold: valid=%b pc=%h addr=%h expected 1 00000000 00000008",
                     out_valid, out_pc, rom_addr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin
                failures++;
                $display("FAIL bp_drain[%0d]: valid=%b pc=%h expected 1 %h", i, out_valid, out_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_fault_halt();
        logic [31:0] exp_perf;
        bad_addr = 32'h0000_000C;
        apply_reset(1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hC || out_inst !== 32'h0 || out_fault !== 1'b1) begin
            failures++;
            $display("FAIL fault_entry: valid=%b pc=%h inst=%h fault=%b expected 1 0000000c 00000000 1",
                     out_valid, out_pc, out_inst, out_fault);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || rom_addr !== 32'hC) begin
                failures++;
                $display("FAIL halt[%0d]: valid=%b addr=%h expected 0 0000000c", i, out_valid, rom_addr);
            end
        end
`ifdef FETCH_PERF_EN
        exp_perf = 32'd4;
`else
        exp_perf = 32'd0;
`endif
        checks++;
        if (perf_fetch_cnt !== exp_perf) begin
            failures++;
            $display("FAIL halt_perf: got %0d expected %0d", perf_fetch_cnt, exp_perf);
        end
    endtask

    task automatic test_redirect_halt();
        logic [31:0] exp_perf;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0000;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 32'h0040_0000) begin
            failures++;
            $display("FAIL redir_halt_flush: valid=%b addr=%h expected 0 00400000", out_valid, rom_addr);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000 || out_inst !== 32'hC0DE_0000 || out_fault !== 1'b0) begin
            failures++;
            $display("FAIL redir_halt_first: valid=%b pc=%h inst=%h fault=%b expected 1 00400000 c0de0000 0",
                     out_valid, out_pc, out_inst, out_fault);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0040_0004 || out_inst !== 32'hC0DE_0004) begin
            failures++;
            $display("FAIL redir_halt_second: valid=%b pc=%h inst=%h expected 1 00400004 c0de0004",
                     out_valid, out_pc, out_inst);
        end
`ifdef FETCH_PERF_EN
        exp_perf = 32'd6;
`else
        exp_perf = 32'd0;
`endif
        checks++;
        if (perf_fetch_cnt !== exp_perf) begin
            failures++;
            $display("FAIL redir_perf: got %0d expected %0d", perf_fetch_cnt, exp_perf);
        end
    endtask

    task automatic test_redirect_full();
        bad_addr = 32'hFFFF_FFF0;
        apply_reset(1'b0);
        repeat (3) @(negedge clk);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0010;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_full_flush: valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0040_0010 || out_inst !== 32'hC0DE_0010) begin
            failures++;
            $display("FAIL redir_full_first: valid=%b pc=%h inst=%h expected 1 00400010 c0de0010",
                     out_valid, out_pc, out_inst);
        end
    endtask

    task automatic test_misaligned_and_async_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0002;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0040_0002 || out_inst !== 32'h0 || out_fault !== 1'b1) begin
            failures++;
            $display("FAIL misaligned: valid=%b pc=%h inst=%h fault=%b expected 1 00400002 00000000 1",
                     out_valid, out_pc, out_inst, out_fault);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0020;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b addr=%h expected 0 00000000", out_valid, rom_addr);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        bad_addr       = 32'hFFFF_FFF0;
        test_reset();
        test_stream();
        test_backpressure();
        test_fault_halt();
        test_redirect_halt();
        test_redirect_full();
        test_misaligned_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
